// File: rtl/fb_pkg.sv
// Shared constants, state encoding and address helper for the frame-buffer rectangle writer.
package fb_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int IDX_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FILL    = 2'd2,
        ST_DONE    = 2'd3
    } fb_state_t;

    // Linear row-major address of an on-screen pixel.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        pix_addr = ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_vs_edge.sv
// Falling-edge detector on the active-low vertical sync; the history register resets high.
module fb_vs_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic fall
);

    logic vs_prev_r;

    // Remember the previous VS level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_r <= 1'b1;
        end else begin
            vs_prev_r <= vs;
        end
    end

    assign fall = vs_prev_r & ~vs;

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: clips a command to the screen and streams one frame-buffer write per clock.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iVS,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [8:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [IDX_W-1:0]  cmd_index,
    input  logic              cmd_sync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IDX_W-1:0]  wr_data,
    output logic              done
);

    fb_state_t         state_r;
    logic [9:0]        cw_r;
    logic [8:0]        ch_r;
    logic [9:0]        col_r;
    logic [8:0]        row_r;
    logic [ADDR_W-1:0] line_r;
    logic [IDX_W-1:0]  idx_r;

    logic [10:0]       rem_x_s;
    logic [10:0]       rem_y_s;
    logic [10:0]       cw_s;
    logic [10:0]       ch_s;
    logic              vs_fall_s;
    logic              col_last_s;
    logic              row_last_s;

    fb_vs_edge u_vs_edge (
        .clk   (iVGA_CLK),
        .rst_n (iRST_n),
        .vs    (iVS),
        .fall  (vs_fall_s)
    );

    assign cmd_ready  = (state_r == ST_IDLE);
    assign col_last_s = (col_r == cw_r - 10'd1);
    assign row_last_s = (row_r == ch_r - 9'd1);

    // Clip the incoming command against the screen edges using 11-bit arithmetic.
    always_comb begin
        rem_x_s = 11'(H_RES) - {1'b0, cmd_x};
        rem_y_s = 11'(V_RES) - {2'b00, cmd_y};
        cw_s    = 11'd0;
        ch_s    = 11'd0;
        if ({1'b0, cmd_x} >= 11'(H_RES)) begin
            cw_s = 11'd0;
        end else if ({1'b0, cmd_w} < rem_x_s) begin
            cw_s = {1'b0, cmd_w};
        end else begin
            cw_s = rem_x_s;
        end
        if ({2'b00, cmd_y} >= 11'(V_RES)) begin
            ch_s = 11'd0;
        end else if ({2'b00, cmd_h} < rem_y_s) begin
            ch_s = {2'b00, cmd_h};
        end else begin
            ch_s = rem_y_s;
        end
    end

    // Control FSM; wr_* always present the write for the current FILL cycle.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_r <= ST_IDLE;
            cw_r    <= 10'd0;
            ch_r    <= 9'd0;
            col_r   <= 10'd0;
            row_r   <= 9'd0;
            line_r  <= {ADDR_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            wr_en   <= 1'b0;
            wr_addr <= {ADDR_W{1'b0}};
            wr_data <= {IDX_W{1'b0}};
            done    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (cmd_valid) begin
                        cw_r   <= cw_s[9:0];
                        ch_r   <= ch_s[8:0];
                        col_r  <= 10'd0;
                        row_r  <= 9'd0;
                        line_r <= pix_addr(cmd_x, cmd_y);
                        idx_r  <= cmd_index;
                        if ((cw_s == 11'd0) || (ch_s == 11'd0)) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else if (cmd_sync) begin
                            state_r <= ST_WAIT_VS;
                        end else begin
                            state_r <= ST_FILL;
                            wr_en   <= 1'b1;
                            wr_addr <= pix_addr(cmd_x, cmd_y);
                            wr_data <= cmd_index;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall_s) begin
                        state_r <= ST_FILL;
                        wr_en   <= 1'b1;
                        wr_addr <= line_r;
                        wr_data <= idx_r;
                    end else begin
                        state_r <= ST_WAIT_VS;
                    end
                end
                ST_FILL: begin
                    if (col_last_s && row_last_s) begin
                        state_r <= ST_DONE;
                        wr_en   <= 1'b0;
                        done    <= 1'b1;
                    end else if (col_last_s) begin
                        col_r   <= 10'd0;
                        row_r   <= row_r + 9'd1;
                        line_r  <= line_r + ADDR_W'(H_RES);
                        wr_addr <= line_r + ADDR_W'(H_RES);
                    end else begin
                        col_r   <= col_r + 10'd1;
                        wr_addr <= wr_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    wr_en   <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    wr_en   <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: vector table, write scoreboard and multi-cycle corner sequences.
module tb_fb_rect_writer;

    logic        clk;
    logic        rst_n;
    logic        vs;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [7:0]  cmd_index;
    logic        cmd_sync;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        done;

    fb_rect_writer dut (
        .iVGA_CLK  (clk),
        .iRST_n    (rst_n),
        .iVS       (vs),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_index (cmd_index),
        .cmd_sync  (cmd_sync),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic [9:0] w;
        logic [8:0] h;
        logic [7:0] idx;
        int         n;
        int         first;
        int         last;
    } vec_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  fails = 0;
    int  cyc = 0;
    int  wr_count = 0;
    int  done_count = 0;
    int  done_cyc = 0;
    int  first_wr_cyc = 0;
    int  first_wr_addr = 0;
    int  last_wr_addr = 0;
    int  acc_cyc = 0;
    bit  prev_wr = 1'b0;
    bit  sb_ignore = 1'b0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst_n) begin
            prev_wr = 1'b0;
        end else begin
            if (wr_en) begin
                wr_count++;
                if (!prev_wr) begin
                    first_wr_cyc  = cyc;
                    first_wr_addr = int'(wr_addr);
                end
                last_wr_addr = int'(wr_addr);
                if (!sb_ignore) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 1'b0, longint'(wr_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", wr_addr === e.addr, longint'(wr_addr), longint'(e.addr));
                        check("wr_data", wr_data === e.data, longint'(wr_data), longint'(e.data));
                    end
                end
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            prev_wr = wr_en;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_rect(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                             input logic [8:0] h, input logic [7:0] idx);
        int cw, ch;
        wr_t e;
        cw = (int'(x) >= 640) ? 0 : ((int'(w) < 640 - int'(x)) ? int'(w) : 640 - int'(x));
        ch = (int'(y) >= 480) ? 0 : ((int'(h) < 480 - int'(y)) ? int'(h) : 480 - int'(y));
        for (int r = 0; r < ch; r++) begin
            for (int c = 0; c < cw; c++) begin
                e.addr = 19'((int'(y) + r) * 640 + int'(x) + c);
                e.data = idx;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                         input logic [8:0] h, input logic [7:0] idx, input logic sync);
        cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_index = idx; cmd_sync = sync;
        cmd_valid = 1'b1;
        if (!sb_ignore) push_rect(x, y, w, h, idx);
    endtask

    task automatic send(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                        input logic [8:0] h, input logic [7:0] idx, input logic sync,
                        input logic drop_vs);
        int n;
        n = 0;
        tick();
        while (!cmd_ready && n < 2000) begin
            tick();
            n++;
        end
        check("ready_before_send", cmd_ready === 1'b1, longint'(cmd_ready), 1);
        if (drop_vs) vs = 1'b0;
        drive(x, y, w, h, idx, sync);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat);
        int start, n;
        start = done_count;
        n = 0;
        while (done_count == start && n < 20000) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, done_count != start, longint'(done_count - start), 1);
        if (exp_lat >= 0)
            check({name, "_latency"}, (done_cyc - acc_cyc) == exp_lat, longint'(done_cyc - acc_cyc), longint'(exp_lat));
        tick();
        check({name, "_ready_after"}, cmd_ready === 1'b1, longint'(cmd_ready), 1);
        check({name, "_done_one_cycle"}, done === 1'b0, longint'(done), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   w0, d0, edge_cyc, bad;
        vecs[0] = '{10'd10,  9'd2,   10'd3,   9'd2, 8'h55, 6,  1290,   1932};
        vecs[1] = '{10'd638, 9'd479, 10'd5,   9'd4, 8'hA3, 2,  307198, 307199};
        vecs[2] = '{10'd5,   9'd5,   10'd0,   9'd3, 8'h11, 0,  0,      0};
        vecs[3] = '{10'd640, 9'd0,   10'd4,   9'd4, 8'h22, 0,  0,      0};
        vecs[4] = '{10'd0,   9'd480, 10'd4,   9'd4, 8'h23, 0,  0,      0};
        vecs[5] = '{10'd600, 9'd100, 10'd100, 9'd2, 8'h7E, 80, 64600,  65279};
        vecs[6] = '{10'd0,   9'd0,   10'd1,   9'd1, 8'hFF, 1,  0,      0};

        rst_n = 1'b0; vs = 1'b1; cmd_valid = 1'b0; cmd_sync = 1'b0;
        cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 10'd0; cmd_h = 9'd0; cmd_index = 8'd0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready === 1'b1, longint'(cmd_ready), 1);
        check("rst_wr_en", wr_en === 1'b0, longint'(wr_en), 0);
        check("rst_wr_addr", wr_addr === 19'd0, longint'(wr_addr), 0);
        check("rst_wr_data", wr_data === 8'd0, longint'(wr_data), 0);
        check("rst_done", done === 1'b0, longint'(done), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            w0 = wr_count;
            send(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].idx, 1'b0, 1'b0);
            wait_done($sformatf("vec%0d", i), vecs[i].n + 1);
            check($sformatf("vec%0d_writes", i), (wr_count - w0) == vecs[i].n, longint'(wr_count - w0), longint'(vecs[i].n));
            if (vecs[i].n > 0) begin
                check($sformatf("vec%0d_first_cycle", i), first_wr_cyc == acc_cyc + 1, longint'(first_wr_cyc - acc_cyc), 1);
                check($sformatf("vec%0d_first_addr", i), first_wr_addr == vecs[i].first, longint'(first_wr_addr), longint'(vecs[i].first));
                check($sformatf("vec%0d_last_addr", i), last_wr_addr == vecs[i].last, longint'(last_wr_addr), longint'(vecs[i].last));
            end
        end

        // VS held high for 20 cycles after a sync command, then falls.
        w0 = wr_count;
        send(10'd50, 9'd50, 10'd2, 9'd2, 8'h66, 1'b1, 1'b0);
        repeat (20) tick();
        check("sync1_no_early_write", wr_count == w0, longint'(wr_count - w0), 0);
        vs = 1'b0;
        edge_cyc = cyc;
        wait_done("sync1", -1);
        check("sync1_first_after_edge", first_wr_cyc == edge_cyc + 1, longint'(first_wr_cyc - edge_cyc), 1);
        check("sync1_writes", (wr_count - w0) == 4, longint'(wr_count - w0), 4);

        // VS falls in the very cycle of acceptance; only a later edge may start the fill.
        vs = 1'b1;
        repeat (3) tick();
        w0 = wr_count;
        send(10'd7, 9'd300, 10'd3, 9'd1, 8'h5A, 1'b1, 1'b1);
        repeat (10) tick();
        check("sync2_ignores_old_edge", wr_count == w0, longint'(wr_count - w0), 0);
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        edge_cyc = cyc;
        wait_done("sync2", -1);
        check("sync2_first_after_edge", first_wr_cyc == edge_cyc + 1, longint'(first_wr_cyc - edge_cyc), 1);
        vs = 1'b1;

        // Back-pressure: second command held valid throughout the first fill.
        tick();
        drive(10'd20, 9'd10, 10'd4, 9'd3, 8'h33, 1'b0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        drive(10'd0, 9'd0, 10'd2, 9'd1, 8'h44, 1'b0);
        d0 = done_count;
        bad = 0;
        for (int n = 0; n < 200 && done_count == d0; n++) begin
            tick();
            if (cmd_ready) bad++;
        end
        check("bp_ready_low", bad == 0, longint'(bad), 0);
        check("bp_first_latency", (done_cyc - acc_cyc) == 13, longint'(done_cyc - acc_cyc), 13);
        tick();
        check("bp_ready_after_done", cmd_ready === 1'b1, longint'(cmd_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        wait_done("bp_second", 3);
        check("bp_second_first_cycle", first_wr_cyc == acc_cyc + 1, longint'(first_wr_cyc - acc_cyc), 1);

        // Reset in the middle of a large fill.
        sb_ignore = 1'b1;
        send(10'd0, 9'd0, 10'd100, 9'd100, 8'h99, 1'b0, 1'b0);
        repeat (50) tick();
        check("rst_mid_active", wr_en === 1'b1, longint'(wr_en), 1);
        d0 = done_count;
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en_drop", wr_en === 1'b0, longint'(wr_en), 0);
        check("rst_mid_ready", cmd_ready === 1'b1, longint'(cmd_ready), 1);
        repeat (3) tick();
        check("rst_mid_no_done", done_count == d0, longint'(done_count - d0), 0);
        rst_n = 1'b1;
        sb_ignore = 1'b0;
        drive(10'd3, 9'd4, 10'd1, 9'd1, 8'hC3, 1'b0);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        wait_done("rst_recover", 2);
        check("rst_recover_first_cycle", first_wr_cyc == acc_cyc + 1, longint'(first_wr_cyc - acc_cyc), 1);
        check("rst_recover_addr", first_wr_addr == 2563, longint'(first_wr_addr), 2563);

        repeat (3) tick();
        check("scoreboard_empty", exp_q.size() == 0, longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
